// File: rtl/core2axi_arb_pkg.sv
// core2axi_arb_pkg: shared state encoding and limits for the core-to-AXI arbiter
package core2axi_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_RSP} arb_state_e;
  localparam int MAX_MASTERS = 8;
endpackage

// File: rtl/core2axi_arb_rr_pick.sv
// rr_pick: combinational rotate-priority picker, first set request at or after ptr
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  // rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    winner = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : W'(sum);
  end
  assign valid = |req;
endmodule

// File: rtl/core2axi_arb.sv
// core2axi_arb: round-robin merge of several core-side ports onto one bridge port
module core2axi_arb
  import core2axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   core_clock_en,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0]            m_be_i,
  input  logic [NUM_MASTERS-1:0][31:0]           m_wdata_i,
  output logic [NUM_MASTERS-1:0][31:0]           m_rdata_o,
  output logic                                   data_req_o,
  input  logic                                   data_gnt_i,
  input  logic                                   data_rvalid_i,
  output logic [ADDR_WIDTH-1:0]                  data_addr_o,
  output logic                                   data_we_o,
  output logic [3:0]                             data_be_o,
  output logic [31:0]                            data_wdata_o,
  input  logic [31:0]                            data_rdata_i
);
  localparam int IW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_n
    $error("core2axi_arb: NUM_MASTERS out of range");
  end

  arb_state_e    state, state_n;
  logic [IW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, win, sel;
  logic          any;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(NUM_MASTERS - 1)) ? '0 : x + 1'b1;
  endfunction

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (m_req_i),
    .ptr   (rr_ptr),
    .winner(win),
    .valid (any)
  );

  // state, owner and pointer advance only on enabled cycles; reset ignores the enable
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (core_clock_en) begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_ptr_n;
    end
  end

  // next state plus zero-latency grant/response routing; once committed, the owner drives the bridge
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    sel        = (state == IDLE) ? (any ? win : '0) : owner;
    data_req_o = (state == IDLE) ? any : (state == LOCKED);
    case (state)
      IDLE: if (any) begin
        owner_n = win;
        state_n = data_gnt_i ? WAIT_RSP : LOCKED;
        if (data_gnt_i) begin
          m_gnt_o[win] = 1'b1;
          rr_ptr_n     = inc(win);
        end
      end
      LOCKED: if (data_gnt_i) begin
        m_gnt_o[owner] = 1'b1;
        state_n        = WAIT_RSP;
        rr_ptr_n       = inc(owner);
      end
      WAIT_RSP: if (data_rvalid_i) begin
        m_rvalid_o[owner] = 1'b1;
        state_n           = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign data_addr_o  = m_addr_i[sel];
  assign data_we_o    = m_we_i[sel];
  assign data_be_o    = m_be_i[sel];
  assign data_wdata_o = m_wdata_i[sel];
  assign m_rdata_o    = {NUM_MASTERS{data_rdata_i}};

  a_rvalid_only_waiting: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_rvalid_i && state != WAIT_RSP));
  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(m_gnt_o) && $onehot0(m_rvalid_o));
endmodule
